// File: rtl/bus_transfer_ctrl.sv
// Bus transfer sequencer: moves one word from a register (or external input) to a register.
// Optional macro TRANSFER_COUNT_EN adds a 16-bit count of successful transfers.
module bus_transfer_ctrl #(
  parameter int p_data_width = 8,
  parameter int p_reg_count  = 4,
  parameter int p_sel_width  = 2
) (
  input  logic                                i_w_clk,
  input  logic                                i_w_reset,
  input  logic                                i_w_req_valid,
  output logic                                o_w_req_ready,
  input  logic [p_sel_width-1:0]              i_w_src_sel,
  input  logic [p_sel_width-1:0]              i_w_dst_sel,
  input  logic                                i_w_ext_src,
  input  logic [p_data_width-1:0]             i_w_ext_data,
  input  logic [p_reg_count*p_data_width-1:0] i_w_reg_out,
  output logic [p_data_width-1:0]             o_w_bus,
  output logic [p_reg_count-1:0]              o_w_oe,
  output logic [p_reg_count-1:0]              o_w_we,
  output logic                                o_w_busy,
`ifdef TRANSFER_COUNT_EN
  output logic [15:0]                         o_w_xfer_count,
`endif
  output logic                                o_w_done,
  output logic                                o_w_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [p_sel_width-1:0] src_q, src_d;
  logic [p_sel_width-1:0] dst_q, dst_d;
  logic                   ext_q, ext_d;
  logic                   err_q, err_d;
  logic                   req_bad;
  logic                   accept;
  logic                   drive_phase;

  assign o_w_req_ready = (state_q == IDLE) && !i_w_reset;
  assign accept        = i_w_req_valid && o_w_req_ready;
  assign req_bad       = (!i_w_ext_src && (int'(i_w_src_sel) >= p_reg_count)) ||
                         (int'(i_w_dst_sel) >= p_reg_count);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ext_d   = ext_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = i_w_src_sel;
          dst_d   = i_w_dst_sel;
          ext_d   = i_w_ext_src;
          err_d   = req_bad;
          state_d = req_bad ? DONE : DRIVE;
        end
      end
      DRIVE:   state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode only from registered state and latches, never from the request inputs.
  assign drive_phase = (state_q == DRIVE) || (state_q == WRITE);

  generate
    for (genvar gi = 0; gi < p_reg_count; gi++) begin : g_strobe
      assign o_w_oe[gi] = drive_phase && !ext_q && (src_q == p_sel_width'(gi));
      assign o_w_we[gi] = (state_q == WRITE) && (dst_q == p_sel_width'(gi));
    end
  endgenerate

  always_comb begin
    o_w_bus = (drive_phase && ext_q) ? i_w_ext_data : '0;
    for (int k = 0; k < p_reg_count; k++) begin
      o_w_bus = o_w_bus | i_w_reg_out[k*p_data_width +: p_data_width];
    end
  end

  assign o_w_busy = (state_q != IDLE);
  assign o_w_done = (state_q == DONE);
  assign o_w_err  = (state_q == DONE) && err_q;

`ifdef TRANSFER_COUNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if ((state_q == DONE) && !err_q) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign o_w_xfer_count = xfer_count_q;
`endif

endmodule

// File: doc/bus_transfer_ctrl.md
Name: bus_transfer_ctrl

Overview:
- Sequencer that moves one data word between registers sharing a common data bus, or from an external input into a register.
- Drives per-register output-enable (oe) and write-enable (we) strobes.
- Merges the gated register outputs onto the bus. Each register drives zero when its oe is low, so the bus is an OR of all register outputs.
- Sits upstream of the register bank. It feeds each register's we, oe and data-in, and consumes each register's gated output.

Parameters:
- p_data_width, 8, width of each register and of the bus
- p_reg_count, 4, number of registers attached to the bus
- p_sel_width, 2, width of the src/dst select fields; must satisfy 2**p_sel_width >= p_reg_count

Ports:
- i_w_clk  input  1  clock; all state changes on rising edge
- i_w_reset  input  1  asynchronous, active-high reset
- i_w_req_valid  input  1  transfer request valid
- o_w_req_ready  output  1  controller can accept a request
- i_w_src_sel  input  p_sel_width  source register index
- i_w_dst_sel  input  p_sel_width  destination register index
- i_w_ext_src  input  1  1 = source is i_w_ext_data instead of a register
- i_w_ext_data  input  p_data_width  external source word
- i_w_reg_out  input  p_reg_count*p_data_width  packed gated register outputs; slice k belongs to register k
- o_w_bus  output  p_data_width  merged bus value; wired to every register's data-in
- o_w_oe  output  p_reg_count  one-hot-or-zero output enables
- o_w_we  output  p_reg_count  one-hot-or-zero write enables
- o_w_busy  output  1  transfer in progress (any state other than IDLE)
- o_w_done  output  1  one-cycle pulse when a transfer finishes
- o_w_err  output  1  one-cycle pulse, coincident with o_w_done, on an invalid request

Behaviour:
- Reset (i_w_reset high, asynchronous):
  - State goes to IDLE; latched src/dst/ext are cleared.
  - o_w_oe, o_w_we, o_w_done, o_w_err and o_w_busy are all 0.
  - o_w_req_ready is forced to 0 while reset is high.
  - A reset in mid-transfer aborts the transfer immediately; no we pulse completes.
- FSM states: IDLE, DRIVE, WRITE, DONE.
- IDLE:
  - o_w_req_ready = 1.
  - On valid & ready at a clock edge, latch src, dst and ext.
  - If the request is valid (see invalid request below), go to DRIVE; otherwise go to DONE with an error latched.
- DRIVE (1 cycle):
  - o_w_oe[src] = 1 (all zeros if ext); o_w_we = 0. The bus settles during this cycle.
  - Go to WRITE.
- WRITE (1 cycle):
  - oe held as in DRIVE; o_w_we[dst] = 1.
  - The destination captures o_w_bus at the rising edge that ends this cycle.
  - Go to DONE.
- DONE (1 cycle):
  - oe = 0, we = 0, o_w_done = 1, o_w_err = latched error flag.
  - o_w_req_ready = 0. Go to IDLE.
- Latency and throughput:
  - 3 cycles from the accept edge to o_w_done high.
  - Maximum throughput is 1 transfer per 4 cycles.
- Invalid request:
  - Condition: (!ext and src >= p_reg_count) or dst >= p_reg_count.
  - Sequence: IDLE -> DONE directly; no oe or we asserted; o_w_done = 1 and o_w_err = 1.
- src == dst (non-ext): legal. The register reloads its own value; the contents are unchanged.
- o_w_bus (combinational):
  - Bitwise OR of all p_reg_count slices of i_w_reg_out.
  - Also ORed with i_w_ext_data when ext is latched and state is DRIVE or WRITE; otherwise the ext data term is 0.
- Request inputs are ignored outside IDLE; valid may be held high across transfers.
- All strobes are registered from state/latches. No combinational path exists from i_w_req_valid to oe or we.

Optional Feature:
- Macro: TRANSFER_COUNT_EN.
- Defined:
  - Adds output port o_w_xfer_count, 16 bits: count of successful transfers, incremented on each DONE cycle with err = 0.
  - Reset value 0; wraps from 16'hFFFF to 16'h0000.
  - Errored transfers do not count.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: assert i_w_reset for 3 cycles mid-clock, then release.
  - Required: all outputs 0 during reset; o_w_req_ready = 1 on the first cycle after release.
- Register-to-register move:
  - Stimulus: with reg1 = 8'hA5 and reg2 = 8'h00 in the attached bank, request src = 1, dst = 2.
  - Required: oe = 4'b0010 in DRIVE and WRITE; we = 4'b0100 in WRITE only; done pulses 3 cycles after accept; reg2 = 8'hA5 afterwards.
- External load:
  - Stimulus: ext = 1, ext_data = 8'h3C, dst = 0.
  - Required: oe = 0 throughout; o_w_bus = 8'h3C in DRIVE and WRITE; reg0 = 8'h3C; err = 0.
- Invalid request:
  - Stimulus: with p_reg_count = 3, request dst = 3.
  - Required: no oe or we at any cycle; done = 1 and err = 1 on the cycle after accept.
  - If TRANSFER_COUNT_EN is defined, the count is unchanged.
- Reset mid-transfer and back-to-back requests:
  - Stimulus: assert reset during WRITE.
  - Required: we drops immediately; state is IDLE; the destination register is not written.
  - Stimulus: hold valid high for two requests.
  - Required: the second request is accepted exactly 4 cycles after the first.
  - With TRANSFER_COUNT_EN defined and the count preset near 16'hFFFF: the count wraps to 0.
